// File: rtl/pencoder_pkg.sv
// Shared types and width helpers for the sequential leading-one walker.
package pencoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/pencoder_lead.sv
// Combinational MSB-first priority encoder: bit WIDTH-1 maps to index 0.
module pencoder_lead #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             is_zero
);

  // Scan upward so the highest set bit is the last one to write idx.
  always_comb begin
    idx     = '0;
    is_zero = ~|mask;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) idx = IDX_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/pencoder_seq.sv
// Sequential leading-one walker: one set-bit index per beat, MSB first.
// Optional PENCODER_SEQ_POPCNT_EN adds out_popcnt, the set-bit count of the accepted mask.
module pencoder_seq
  import pencoder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bitmask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_is_zero,
  output logic             busy
`ifdef PENCODER_SEQ_POPCNT_EN
  ,
  output logic [IDX_W:0]   out_popcnt
`endif
);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never waits on ready, and in_ready may depend on out_ready.
  state_t           state, state_d;
  logic [WIDTH-1:0] mask_q;
  logic             zero_q;
  logic [WIDTH-1:0] clr;
  logic             lead_zero;
  logic             accept, beat;

  pencoder_lead #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lead (
    .mask    (mask_q),
    .idx     (out_idx),
    .is_zero (lead_zero)
  );

  always_comb begin
    clr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clr[i] = (out_idx == IDX_W'(WIDTH - 1 - i));
    end
  end

  // Final beat: nothing left once the current leading one is removed.
  assign out_valid   = (state == SCAN);
  assign busy        = (state == SCAN);
  assign out_last    = out_valid && (lead_zero || ((mask_q & ~clr) == '0));
  assign out_is_zero = out_valid && zero_q;
  assign beat        = out_valid && out_ready;
  assign in_ready    = (state == IDLE) || (beat && out_last);
  assign accept      = in_valid && in_ready;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (beat && out_last) state_d = accept ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mask_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        mask_q <= in_bitmask;
        zero_q <= (in_bitmask == '0);
      end else if (beat) begin
        mask_q <= mask_q & ~clr;
      end
    end
  end

`ifdef PENCODER_SEQ_POPCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_popcnt <= '0;
    end else if (accept) begin
      out_popcnt <= (IDX_W + 1)'($countones(in_bitmask));
    end
  end
`endif

endmodule

// File: tb/tb_pencoder_seq.sv
// Bench for pencoder_seq: queue-based beat model on an 8-bit instance plus a 32-bit reset-abort case.
module tb_pencoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- 8-bit instance ----------------
  logic       reset, in_valid, out_ready;
  logic [7:0] in_bitmask;
  logic       in_ready, out_valid, out_last, out_is_zero, busy;
  logic [2:0] out_idx;
`ifdef PENCODER_SEQ_POPCNT_EN
  logic [3:0] out_popcnt;
`endif

  pencoder_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_bitmask(in_bitmask), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_is_zero(out_is_zero), .busy(busy)
`ifdef PENCODER_SEQ_POPCNT_EN
    , .out_popcnt(out_popcnt)
`endif
  );

  // ---------------- 32-bit instance ----------------
  logic        reset32, in_valid32, out_ready32;
  logic [31:0] in_bitmask32;
  logic        in_ready32, out_valid32, out_last32, out_is_zero32, busy32;
  logic [4:0]  out_idx32;
`ifdef PENCODER_SEQ_POPCNT_EN
  logic [5:0]  out_popcnt32;
`endif

  pencoder_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset32), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_bitmask(in_bitmask32), .out_valid(out_valid32), .out_ready(out_ready32),
    .out_idx(out_idx32), .out_last(out_last32), .out_is_zero(out_is_zero32), .busy(busy32)
`ifdef PENCODER_SEQ_POPCNT_EN
    , .out_popcnt(out_popcnt32)
`endif
  );

  // Model entry: {popcnt[3:0], is_zero, last, idx[2:0]}
  logic [8:0] exp_q[$];
  int         beat_idx[$];
  int         beat_last[$];
  int         beat_cyc[$];
  logic       acc_now  = 1'b0;
  logic       after_rst = 1'b1;
  int         cyc = 0;

  task automatic model_push(input logic [7:0] m);
    int n;
    int k;
    n = 0;
    for (int b = 0; b < 8; b++) n += m[b];
    if (n == 0) begin
      exp_q.push_back({4'd0, 1'b1, 1'b1, 3'd0});
    end else begin
      k = 0;
      for (int b = 7; b >= 0; b--) begin
        if (m[b]) begin
          k++;
          exp_q.push_back({4'(n), 1'b0, (k == n), 3'(7 - b)});
        end
      end
    end
  endtask

  // Compare process: checks every cycle away from the active edge.
  always @(negedge clk) begin
    logic       exp_ready;
    logic [8:0] head;
    cyc++;
    if (reset) begin
      exp_q.delete();
      acc_now   = 1'b0;
      after_rst = 1'b1;
    end else begin
      exp_ready = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("busy", busy, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("out_idx", out_idx, head[2:0]);
        chk("out_last", out_last, head[3]);
        chk("out_is_zero", out_is_zero, head[4]);
`ifdef PENCODER_SEQ_POPCNT_EN
        chk("out_popcnt", out_popcnt, head[8:5]);
`endif
        if (out_ready) begin
          beat_idx.push_back(int'(head[2:0]));
          beat_last.push_back(int'(head[3]));
          beat_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_idx", out_idx, 0);
        chk("idle_last", out_last, 0);
        chk("idle_is_zero", out_is_zero, 0);
`ifdef PENCODER_SEQ_POPCNT_EN
        if (after_rst) chk("rst_popcnt", out_popcnt, 0);
`endif
      end
      acc_now = in_valid && exp_ready;
      if (acc_now) begin
        model_push(in_bitmask);
        after_rst = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] m);
    int n;
    in_valid   = 1'b1;
    in_bitmask = m;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_now && n < 50);
    if (!acc_now) chk("accept_timeout", 0, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (exp_q.size() != 0) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    beat_idx.delete();
    beat_last.delete();
    beat_cyc.delete();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bitmask = '0; out_ready = 1'b1;
    reset32 = 1'b1; in_valid32 = 1'b0; in_bitmask32 = '0; out_ready32 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; reset32 = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // A1: beats 0,2,7 on consecutive cycles, last only on 7
    clear_log();
    send(8'hA1);
    wait_idle();
    chk("a1_count", beat_idx.size(), 3);
    if (beat_idx.size() == 3) begin
      chk("a1_idx0", beat_idx[0], 0);
      chk("a1_idx1", beat_idx[1], 2);
      chk("a1_idx2", beat_idx[2], 7);
      chk("a1_last", {beat_last[0][0], beat_last[1][0], beat_last[2][0]}, 3'b001);
      chk("a1_gap", beat_cyc[2] - beat_cyc[0], 2);
    end

    // all-zero mask: single beat idx 0
    clear_log();
    send(8'h00);
    wait_idle();
    chk("zero_count", beat_idx.size(), 1);
    if (beat_idx.size() == 1) chk("zero_idx", beat_idx[0], 0);

    // back-to-back 80 then 01, no bubble
    clear_log();
    send(8'h80);
    send(8'h01);
    wait_idle();
    chk("b2b_count", beat_idx.size(), 2);
    if (beat_idx.size() == 2) begin
      chk("b2b_idx", {beat_idx[0][2:0], beat_idx[1][2:0]}, {3'd0, 3'd7});
      chk("b2b_gap", beat_cyc[1] - beat_cyc[0], 1);
    end

    // FF with out_ready toggling: 8 beats, no drops or duplicates
    clear_log();
    send(8'hFF);
    for (int i = 0; i < 20; i++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    chk("ff_count", beat_idx.size(), 8);
    if (beat_idx.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("ff_idx", beat_idx[i], i);
    end

    // 6C: 4 beats (popcount checked against model when enabled)
    clear_log();
    send(8'h6C);
    wait_idle();
    chk("6c_count", beat_idx.size(), 4);
    if (beat_idx.size() == 4) chk("6c_first", beat_idx[0], 1);

    // 32-bit: reset on the cycle after acceptance aborts the transaction
    in_valid32 = 1'b1; in_bitmask32 = 32'h0001_0000;
    @(negedge clk);
    chk("w32_ready", in_ready32, 1);
    @(posedge clk);
    #1 in_valid32 = 1'b0; reset32 = 1'b1;
    @(negedge clk);
    chk("w32_valid_pre", out_valid32, 1);
    chk("w32_idx_pre", out_idx32, 15);
    @(posedge clk);
    #1 reset32 = 1'b0; out_ready32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w32_abort_valid", out_valid32, 0);
      chk("w32_abort_ready", in_ready32, 1);
      chk("w32_abort_busy", busy32, 0);
    end
`ifdef PENCODER_SEQ_POPCNT_EN
    chk("w32_rst_popcnt", out_popcnt32, 0);
`endif
    @(posedge clk);
    #1 in_valid32 = 1'b1; in_bitmask32 = 32'h8000_0000;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    @(negedge clk);
    chk("w32_valid", out_valid32, 1);
    chk("w32_idx", out_idx32, 0);
    chk("w32_last", out_last32, 1);
    chk("w32_zero", out_is_zero32, 0);
    @(posedge clk);
    @(negedge clk);
    chk("w32_done", out_valid32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
